// File: rtl/vanilla_pkg.sv
// Shared types and constants for the MMIO WISHBONE interconnect.
// The default register-address and data widths are set here when the build
// does not define them. The optional watchdog is enabled by the
// MMIO_TIMEOUT_EN macro; see mmio_wb_intercon.sv.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package vanilla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } intercon_state_t;

    // One bit per slot; a set bit marks an unpopulated slot that must answer with ERR.
    // Slot 7 has no peripheral fitted on this board.
    localparam logic [31:0] MMIO_SLOT_MASK = 32'h0000_0080;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mmio_timeout_cnt.sv
// Bus-timeout watchdog counter for mmio_wb_intercon.
// Compiled only when MMIO_TIMEOUT_EN is defined.
// o_tc is high during the TERMINAL-th consecutive enabled cycle after a clear.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifdef MMIO_TIMEOUT_EN
module mmio_timeout_cnt
    import vanilla_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int TERMINAL = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles; cleared whenever the FSM is outside BUSY.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = i_en && (r_cnt == CNT_W'(TERMINAL - 1));

endmodule
`endif

// File: rtl/mmio_wb_intercon.sv
// Single-master WISHBONE interconnect: decodes the upper master address bits
// into a slot, strobes that slot, and returns one registered ACK/ERR pulse.
// Optional feature macro: MMIO_TIMEOUT_EN (abort BUSY after TIMEOUT_CYCLES).
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mmio_wb_intercon
    import vanilla_pkg::*;
#(
    parameter int NUM_SLOTS      = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                                         CLK_I,
    input  logic                                         RST_NI,
    input  logic [`REG_ADDR_WIDTH+$clog2(NUM_SLOTS)-1:0] M_ADR_I,
    input  logic [`DATA_WIDTH-1:0]                       M_DAT_I,
    output logic [`DATA_WIDTH-1:0]                       M_DAT_O,
    input  logic                                         M_CYC_I,
    input  logic                                         M_STB_I,
    input  logic                                         M_WE_I,
    output logic                                         M_ACK_O,
    output logic                                         M_ERR_O,
    output logic [`REG_ADDR_WIDTH-1:0]                   S_ADR_O,
    output logic [`DATA_WIDTH-1:0]                       S_DAT_O,
    output logic                                         S_WE_O,
    output logic [NUM_SLOTS-1:0]                         S_CYC_O,
    output logic [NUM_SLOTS-1:0]                         S_STB_O,
    input  logic [NUM_SLOTS*`DATA_WIDTH-1:0]             S_DAT_I,
    input  logic [NUM_SLOTS-1:0]                         S_ACK_I
);

    localparam int SLOT_BITS = $clog2(NUM_SLOTS);
    localparam int RAW       = `REG_ADDR_WIDTH;
    localparam int DW        = `DATA_WIDTH;

    // The slot mask is defined for up to 32 slots.
    if ((NUM_SLOTS < 2) || ((NUM_SLOTS & (NUM_SLOTS - 1)) != 0) || (NUM_SLOTS > 32) ||
        (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
        $error("mmio_wb_intercon: unsupported NUM_SLOTS or TIMEOUT_CYCLES");
    end

    localparam logic [NUM_SLOTS-1:0] SLOT_MASK = MMIO_SLOT_MASK[NUM_SLOTS-1:0];

    intercon_state_t      r_state;
    logic [SLOT_BITS-1:0] r_sel;
    logic [RAW-1:0]       r_sadr;
    logic [DW-1:0]        r_sdat;
    logic                 r_we;
    logic [NUM_SLOTS-1:0] r_stb;
    logic [DW-1:0]        r_mdat;
    logic                 r_ack;
    logic                 r_err;

    logic [SLOT_BITS-1:0] w_slot;
    logic                 w_mapped;
    logic [NUM_SLOTS-1:0] w_onehot;
    logic [DW-1:0]        w_rdata;
    logic                 w_sel_ack;

    assign w_slot    = M_ADR_I[RAW +: SLOT_BITS];
    assign w_mapped  = !SLOT_MASK[w_slot];
    assign w_onehot  = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << w_slot;
    // Only the slot latched at request time can complete the transfer.
    assign w_rdata   = S_DAT_I[r_sel*DW +: DW];
    assign w_sel_ack = S_ACK_I[r_sel];

`ifdef MMIO_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic w_timeout;

    mmio_timeout_cnt #(
        .CNT_W    (TO_W),
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (CLK_I),
        .i_rst_n (RST_NI),
        .i_clr   (r_state != BUSY),
        .i_en    (r_state == BUSY),
        .o_tc    (w_timeout)
    );
`endif

    // Transaction FSM: accept in IDLE, strobe the slot in BUSY, pulse ACK/ERR in RESP.
    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_sadr  <= '0;
            r_sdat  <= '0;
            r_we    <= 1'b0;
            r_stb   <= '0;
            r_mdat  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (M_CYC_I && M_STB_I) begin
                        r_sel  <= w_slot;
                        r_sadr <= M_ADR_I[RAW-1:0];
                        r_sdat <= M_DAT_I;
                        r_we   <= M_WE_I;
                        if (w_mapped) begin
                            r_stb   <= w_onehot;
                            r_state <= BUSY;
                        end else begin
                            r_mdat  <= '0;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                BUSY: begin
                    // A slave ACK in the timeout cycle still completes normally.
                    if (w_sel_ack) begin
                        r_stb   <= '0;
                        r_mdat  <= r_we ? '0 : w_rdata;
                        r_ack   <= 1'b1;
                        r_state <= RESP;
                    end
`ifdef MMIO_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_stb   <= '0;
                        r_mdat  <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
`endif
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_stb   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign M_DAT_O = r_mdat;
    assign M_ACK_O = r_ack;
    assign M_ERR_O = r_err;
    assign S_ADR_O = r_sadr;
    assign S_DAT_O = r_sdat;
    assign S_WE_O  = r_we;
    assign S_CYC_O = r_stb;
    assign S_STB_O = r_stb;

endmodule

// File: tb/tb_mmio_wb_intercon.sv
// Self-checking bench for mmio_wb_intercon: a cycle-indexed timeline model of
// what every output must show, filled by the transaction driver, plus slave
// models (slot 2 is a free-running 64-bit timer with a control register).
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mmio_wb_intercon;

    localparam int NS  = 8;
    localparam int SB  = 3;
    localparam int RAW = `REG_ADDR_WIDTH;
    localparam int DW  = `DATA_WIDTH;
    localparam int TO  = 16;
    localparam int NC  = 4096;
    localparam logic [63:0]   TIMER_BASE = 64'h0000_1234_0000_0000;
    localparam logic [NS-1:0] UNPOP      = 8'h80;
`ifdef MMIO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [RAW+SB-1:0] m_adr;
    logic [DW-1:0]     m_dat_i, m_dat_o;
    logic              m_cyc, m_stb, m_we, m_ack, m_err;
    logic [RAW-1:0]    s_adr;
    logic [DW-1:0]     s_dat_o;
    logic              s_we;
    logic [NS-1:0]     s_cyc, s_stb, s_ack_i;
    logic [NS*DW-1:0]  s_dat_i;

    always #5 clk = ~clk;

    mmio_wb_intercon #(
        .NUM_SLOTS      (NS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK_I   (clk),
        .RST_NI  (rst_n),
        .M_ADR_I (m_adr),
        .M_DAT_I (m_dat_i),
        .M_DAT_O (m_dat_o),
        .M_CYC_I (m_cyc),
        .M_STB_I (m_stb),
        .M_WE_I  (m_we),
        .M_ACK_O (m_ack),
        .M_ERR_O (m_err),
        .S_ADR_O (s_adr),
        .S_DAT_O (s_dat_o),
        .S_WE_O  (s_we),
        .S_CYC_O (s_cyc),
        .S_STB_O (s_stb),
        .S_DAT_I (s_dat_i),
        .S_ACK_I (s_ack_i)
    );

    // ---------------- cycle counter and bookkeeping ----------------
    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        else
            n_pass++;
    endtask

    // ---------------- slave models ----------------
    // Registered ACK after (1 + k_slot) strobed cycles; ACK stays up one
    // cycle after the strobe drops (the trailing ACK of a registered slave).
    logic [NS-1:0] sack = '0;
    logic [NS-1:0] spur = '0;
    int            k_slot [NS];
    bit            mute   [NS];
    int            scnt   [NS];
    logic [63:0]   tcnt = TIMER_BASE;
    logic [31:0]   ctrl = '0;

    initial for (int i = 0; i < NS; i++) begin k_slot[i] = 0; mute[i] = 1'b0; scnt[i] = 0; end

    always @(posedge clk) begin
        tcnt <= tcnt + 64'd1;
        for (int i = 0; i < NS; i++) begin
            scnt[i] <= s_stb[i] ? scnt[i] + 1 : 0;
            sack[i] <= s_stb[i] && s_cyc[i] && (scnt[i] >= k_slot[i]) && !mute[i];
        end
        if (sack[2] && s_stb[2] && s_we && s_adr == RAW'(2)) ctrl <= s_dat_o;
    end

    always_comb begin
        s_dat_i = '0;
        for (int i = 0; i < NS; i++) begin
            if (i == 2) begin
                case (s_adr)
                    RAW'(0): s_dat_i[i*DW +: DW] = tcnt[31:0];
                    RAW'(1): s_dat_i[i*DW +: DW] = tcnt[63:32];
                    RAW'(2): s_dat_i[i*DW +: DW] = ctrl;
                    default: s_dat_i[i*DW +: DW] = '0;
                endcase
            end else begin
                s_dat_i[i*DW +: DW] = 32'hC0DE_0000 | (32'(i) << 8) | 32'(s_adr);
            end
        end
    end

    assign s_ack_i = sack | spur;

    // ---------------- timeline model ----------------
    bit            e_ack  [NC];
    bit            e_err  [NC];
    bit [NS-1:0]   e_stb  [NC];
    bit [RAW-1:0]  e_adr  [NC];
    bit [DW-1:0]   e_sdat [NC];
    bit            e_we   [NC];
    bit            d_set  [NC];
    bit [DW-1:0]   d_val  [NC];
    bit [31:0]     ctrl_model = '0;

    // What slot `slot` presents for register `rg` during cycle c.
    function automatic logic [DW-1:0] slave_value(input int slot, input int rg, input int c);
        logic [63:0] t;
        t = TIMER_BASE + 64'(c);
        if (slot == 2) begin
            if (rg == 0) return t[31:0];
            if (rg == 1) return t[63:32];
            if (rg == 2) return ctrl_model;
            return '0;
        end
        return 32'hC0DE_0000 | (32'(slot) << 8) | 32'(rg);
    endfunction

    // Compare every cycle against the timeline; M_DAT_O must hold its last result.
    bit [DW-1:0] held = '0;
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NC) begin
            if (d_set[cyc]) held = d_val[cyc];
            chk("m_ack", 64'(m_ack), 64'(e_ack[cyc]));
            chk("m_err", 64'(m_err), 64'(e_err[cyc]));
            chk("m_dat", 64'(m_dat_o), 64'(held));
            chk("s_stb", 64'(s_stb), 64'(e_stb[cyc]));
            chk("s_cyc", 64'(s_cyc), 64'(e_stb[cyc]));
            if (e_stb[cyc] != '0) begin
                chk("s_adr", 64'(s_adr), 64'(e_adr[cyc]));
                chk("s_dat", 64'(s_dat_o), 64'(e_sdat[cyc]));
                chk("s_we", 64'(s_we), 64'(e_we[cyc]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in the current cycle, record the expected timeline,
    // and return one cycle after the response with the request dropped
    // unless hold is set (back-to-back).
    task automatic txn(input int slot, input int rg, input logic [DW-1:0] wd, input bit we,
                       input int k, input bit mt, input bit hold,
                       output int dly, output logic [NS-1:0] stb1,
                       output logic ack, output logic err, output logic [DW-1:0] dat);
        int t0, tr, last;
        t0 = cyc;
        m_adr = {SB'(slot), RAW'(rg)};
        m_dat_i = wd;
        m_we = we;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        k_slot[slot] = k;
        mute[slot] = mt;
        if (UNPOP[slot]) begin
            tr = t0 + 1;
            e_err[tr] = 1'b1;
            d_set[tr] = 1'b1;
            d_val[tr] = '0;
        end else begin
            if (!mt && (!TO_EN || (2 + k) <= TO)) begin
                last = t0 + 2 + k;
                tr = last + 1;
                e_ack[tr] = 1'b1;
                d_set[tr] = 1'b1;
                d_val[tr] = we ? '0 : slave_value(slot, rg, last);
                if (we && slot == 2 && rg == 2) ctrl_model = wd;
            end else begin
                last = t0 + TO;
                tr = last + 1;
                e_err[tr] = 1'b1;
                d_set[tr] = 1'b1;
                d_val[tr] = '0;
            end
            for (int c = t0 + 1; c <= last; c++) begin
                e_stb[c]  = NS'(1) << slot;
                e_adr[c]  = RAW'(rg);
                e_sdat[c] = wd;
                e_we[c]   = we;
            end
        end
        dly = tr - t0;
        step();
        stb1 = s_stb;
        while (cyc < tr) step();
        ack = m_ack;
        err = m_err;
        dat = m_dat_o;
        step();
        if (!hold) begin
            m_cyc = 1'b0;
            m_stb = 1'b0;
            m_we = 1'b0;
        end
    endtask

    initial begin
        #(NC * 10);
        $display("FAIL watchdog: simulation exceeded %0d cycles", NC);
        $fatal(1);
    end

    initial begin
        int            d, d2, t0, t0b;
        logic [NS-1:0] s1;
        logic          a, e;
        logic [DW-1:0] dt, dt2;

        rst_n = 1'b0;
        m_adr = '0; m_dat_i = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_m_ack", 64'(m_ack), 64'd0);
        chk("rst_m_err", 64'(m_err), 64'd0);
        chk("rst_s_stb", 64'(s_stb), 64'd0);
        chk("rst_m_dat", 64'(m_dat_o), 64'd0);
        chk("rst_s_adr", 64'(s_adr), 64'd0);
        step();

        // write timer control register
        txn(2, 2, 32'h1, 1'b1, 0, 1'b0, 1'b0, d, s1, a, e, dt);
        chk("wr_stb_c1", 64'(s1), 64'h04);
        chk("wr_lat", 64'(d), 64'd3);
        chk("wr_ack", 64'(a), 64'd1);
        chk("wr_dat", 64'(dt), 64'd0);
        chk("wr_ctrl", 64'(ctrl), 64'd1);

        // timer read after the counter has run a while
        repeat (100) step();
        t0 = cyc;
        txn(2, 0, '0, 1'b0, 0, 1'b0, 1'b0, d, s1, a, e, dt);
        chk("rd_lat", 64'(d), 64'd3);
        chk("rd_timer", 64'(dt), 64'(t0 + 2));
        step();

        // back-to-back reads with STB held
        t0 = cyc;
        txn(2, 0, '0, 1'b0, 0, 1'b0, 1'b1, d, s1, a, e, dt);
        t0b = cyc;
        txn(2, 1, '0, 1'b0, 0, 1'b0, 1'b0, d2, s1, a, e, dt2);
        chk("b2b_gap", 64'((t0b + d2) - (t0 + d)), 64'd4);
        chk("b2b_lo", 64'(dt), 64'(t0 + 2));
        chk("b2b_hi", 64'(dt2), 64'h0000_1234);
        step();

        // unpopulated slot
        txn(7, 3, '0, 1'b0, 0, 1'b0, 1'b0, d, s1, a, e, dt);
        chk("msk_lat", 64'(d), 64'd1);
        chk("msk_err", 64'(e), 64'd1);
        chk("msk_ack", 64'(a), 64'd0);
        chk("msk_stb", 64'(s1), 64'd0);
        step();

        // stray ACKs on other slots while slot 5 waits two extra cycles
        spur = 8'b1101_1101;
        txn(5, 8'h33, '0, 1'b0, 2, 1'b0, 1'b0, d, s1, a, e, dt);
        spur = '0;
        chk("spur_lat", 64'(d), 64'd5);
        chk("spur_dat", 64'(dt), 64'hC0DE_0533);

        // write with one wait cycle
        txn(0, 1, 32'h0000_A5A5, 1'b1, 1, 1'b0, 1'b0, d, s1, a, e, dt);
        chk("wr0_lat", 64'(d), 64'd4);
        chk("wr0_dat", 64'(dt), 64'd0);

        // leave non-zero read data before the reset test
        txn(6, 8'h80, '0, 1'b0, 0, 1'b0, 1'b0, d, s1, a, e, dt);
        chk("rd6_dat", 64'(dt), 64'hC0DE_0680);

        // reset during BUSY
        t0 = cyc;
        m_adr = {3'd3, 8'd5}; m_dat_i = 32'hDEAD_BEEF; m_we = 1'b1; m_cyc = 1'b1; m_stb = 1'b1;
        k_slot[3] = 5; mute[3] = 1'b0;
        for (int c = t0 + 1; c <= t0 + 2; c++) begin
            e_stb[c] = 8'h08; e_adr[c] = 8'd5; e_sdat[c] = 32'hDEAD_BEEF; e_we[c] = 1'b1;
        end
        d_set[t0 + 3] = 1'b1;
        d_val[t0 + 3] = '0;
        step();
        step();
        rst_n = 1'b0;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        step();
        chk("mrst_stb", 64'(s_stb), 64'd0);
        chk("mrst_we", 64'(s_we), 64'd0);
        chk("mrst_sdat", 64'(s_dat_o), 64'd0);
        chk("mrst_sadr", 64'(s_adr), 64'd0);
        chk("mrst_mdat", 64'(m_dat_o), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (8) step();

        txn(1, 7, '0, 1'b0, 0, 1'b0, 1'b0, d, s1, a, e, dt);
        chk("post_lat", 64'(d), 64'd3);
        chk("post_dat", 64'(dt), 64'hC0DE_0107);

`ifdef MMIO_TIMEOUT_EN
        step();
        txn(3, 4, '0, 1'b0, 0, 1'b1, 1'b0, d, s1, a, e, dt);
        chk("to_lat", 64'(d), 64'd17);
        chk("to_err", 64'(e), 64'd1);
        chk("to_ack", 64'(a), 64'd0);
        step();
        txn(3, 4, '0, 1'b0, 14, 1'b0, 1'b0, d, s1, a, e, dt);
        chk("to_edge_lat", 64'(d), 64'd17);
        chk("to_edge_ack", 64'(a), 64'd1);
        chk("to_edge_dat", 64'(dt), 64'hC0DE_0304);
        step();
        txn(3, 4, '0, 1'b0, 15, 1'b0, 1'b0, d, s1, a, e, dt);
        chk("to_late_err", 64'(e), 64'd1);
`endif

        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
